// File: rtl/vga_frame_capture.sv
// ---------------------------------------------------------------------------
// vga_frame_capture
//
// Write-side tap of the VGA pixel stream. On request it waits for the next
// vertical-sync falling edge and then captures exactly one active frame. Each
// pixel is packed as {8'h00,B,G,R} and pushed into an SDRAM write-FIFO port.
//
// Ports
//   iCLK        pixel clock (clk_vga); every input is synchronous to it
//   iRSTN       asynchronous active-low reset
//   iCAPTURE    one-cycle request to capture the next full frame
//   iVGA_VS     vertical sync, active low
//   iDE         pixel-valid strobe (active-area read enable)
//   iR/iG/iB    8-bit pixel components
//   iWR_FULL    write FIFO full; a pixel offered while full is dropped
//   oWR_DATA    packed pixel {8'h00,B,G,R}
//   oWR         single-cycle write strobe for oWR_DATA
//   oWR_LOAD    one-cycle pulse reloading the FIFO write address at frame start
//   oBUSY       high while armed or capturing
//   oDONE       frame finished; held until the next accepted iCAPTURE
//   oSHORT      sticky: frame cut off by VS before all pixels arrived
//   oOVERFLOW   sticky: at least one pixel dropped because the FIFO was full
//   oPIX_COUNT  pixels seen in the current/last capture, dropped ones included
// ---------------------------------------------------------------------------
module vga_frame_capture #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 19
) (
    input  logic             iCLK,
    input  logic             iRSTN,
    input  logic             iCAPTURE,
    input  logic             iVGA_VS,
    input  logic             iDE,
    input  logic [7:0]       iR,
    input  logic [7:0]       iG,
    input  logic [7:0]       iB,
    input  logic             iWR_FULL,
    output logic [31:0]      oWR_DATA,
    output logic             oWR,
    output logic             oWR_LOAD,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oSHORT,
    output logic             oOVERFLOW,
    output logic [CNT_W-1:0] oPIX_COUNT
);

    localparam int               FRAME_PIX_I = H_ACTIVE * V_ACTIVE;
    localparam logic [CNT_W-1:0] FRAME_PIX   = FRAME_PIX_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAST_PIX    = FRAME_PIX - CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic             vs_d_reg;
    logic [31:0]      wr_data_reg, wr_data_next;
    logic             wr_reg, wr_next;
    logic             load_reg, load_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             short_reg, short_next;
    logic             ovf_reg, ovf_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic vs_fall;
    logic pix_accept;
    logic last_pix;
    logic capture_req;

    assign vs_fall     = vs_d_reg & ~iVGA_VS;
    assign pix_accept  = (state_reg == ST_CAPTURE) & iDE;
    // The final pixel wins over a coincident VS fall: the frame is complete.
    assign last_pix    = pix_accept & (cnt_reg == LAST_PIX);
    // Requests are honoured only when no capture is pending or running.
    assign capture_req = iCAPTURE & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));

    // State register
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_reg <= ST_IDLE;
            vs_d_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            vs_d_reg  <= iVGA_VS;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (iCAPTURE)            state_next = ST_ARMED;
            // A request coinciding with a VS fall still waits for the next VS.
            ST_ARMED:   if (vs_fall)             state_next = ST_CAPTURE;
            ST_CAPTURE: if (last_pix || vs_fall) state_next = ST_DONE;
            ST_DONE:    if (iCAPTURE)            state_next = ST_ARMED;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        busy_next    = (state_next == ST_ARMED) || (state_next == ST_CAPTURE);
        done_next    = (state_next == ST_DONE);
        load_next    = (state_reg == ST_ARMED) && vs_fall;
        wr_next      = pix_accept && !iWR_FULL;
        wr_data_next = wr_data_reg;
        cnt_next     = cnt_reg;
        short_next   = short_reg;
        ovf_next     = ovf_reg;

        if (capture_req) begin
            cnt_next   = '0;
            short_next = 1'b0;
            ovf_next   = 1'b0;
        end

        if (pix_accept) begin
            // Dropped pixels still count so the frame geometry is preserved.
            if (cnt_reg != FRAME_PIX)
                cnt_next = cnt_reg + CNT_W'(1);
            if (iWR_FULL)
                ovf_next = 1'b1;
            else
                wr_data_next = {8'h00, iB, iG, iR};
        end

        if ((state_reg == ST_CAPTURE) && vs_fall && !last_pix)
            short_next = 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            wr_data_reg <= '0;
            wr_reg      <= 1'b0;
            load_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            short_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            wr_data_reg <= wr_data_next;
            wr_reg      <= wr_next;
            load_reg    <= load_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            short_reg   <= short_next;
            ovf_reg     <= ovf_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign oWR_DATA   = wr_data_reg;
    assign oWR        = wr_reg;
    assign oWR_LOAD   = load_reg;
    assign oBUSY      = busy_reg;
    assign oDONE      = done_reg;
    assign oSHORT     = short_reg;
    assign oOVERFLOW  = ovf_reg;
    assign oPIX_COUNT = cnt_reg;

endmodule

// File: tb/tb_vga_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_capture
//
// Drives a reduced 8x4 frame geometry with random pixel data. A frame-level
// reference model pushes every word that should reach the FIFO into a queue;
// a negedge monitor pops and compares on each oWR and checks the status
// outputs every cycle. Per-test totals are checked against fixed numbers.
// ---------------------------------------------------------------------------
module tb_vga_frame_capture;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int CW    = 6;
    localparam int TOTAL = H * V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cap = 1'b0, vs = 1'b1, de = 1'b0, full = 1'b0;
    logic [7:0]    r = '0, g = '0, b = '0;
    logic [31:0]   wr_data;
    logic          wr, wr_load, busy, done, short_f, ovf;
    logic [CW-1:0] pix_count;

    vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
        .iCLK(clk), .iRSTN(rst_n), .iCAPTURE(cap), .iVGA_VS(vs), .iDE(de),
        .iR(r), .iG(g), .iB(b), .iWR_FULL(full),
        .oWR_DATA(wr_data), .oWR(wr), .oWR_LOAD(wr_load), .oBUSY(busy),
        .oDONE(done), .oSHORT(short_f), .oOVERFLOW(ovf), .oPIX_COUNT(pix_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int wr_seen = 0;
    int load_seen = 0;

    // Reference model state
    bit          m_armed, m_cap, m_done, m_short, m_ovf, m_load;
    int          m_cnt;
    bit          vs_prev = 1'b1;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] pack_outputs();
        return 64'({wr_data, wr, wr_load, busy, done, short_f, ovf, pix_count});
    endfunction

    task automatic model_reset();
        m_armed = 0; m_cap = 0; m_done = 0; m_short = 0; m_ovf = 0; m_load = 0;
        m_cnt = 0; vs_prev = 1'b1;
        exp_q.delete();
    endtask

    // One pixel-clock of the frame-level rules, applied to the inputs just sampled.
    task automatic model_step(input bit c, input bit v, input bit d, input bit f, input logic [31:0] w);
        bit fall;
        fall    = vs_prev && !v;
        vs_prev = v;
        m_load  = 0;
        if (m_cap) begin
            if (d) begin
                if (m_cnt < TOTAL) m_cnt++;
                if (f) m_ovf = 1; else exp_q.push_back(w);
            end
            if (d && m_cnt == TOTAL) begin
                m_cap = 0; m_done = 1;
            end else if (fall) begin
                m_cap = 0; m_done = 1; m_short = 1;
            end
        end else if (m_armed) begin
            if (fall) begin
                m_armed = 0; m_cap = 1; m_load = 1;
            end
        end else if (c) begin
            m_armed = 1; m_done = 0; m_short = 0; m_ovf = 0; m_cnt = 0;
        end
    endtask

    task automatic cyc(input bit c, input bit v, input bit d, input bit f,
                       input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        cap = c; vs = v; de = d; full = f; r = rr; g = gg; b = bb;
        @(posedge clk);
        if (rst_n) model_step(c, v, d, f, {8'h00, bb, gg, rr});
        #1;
    endtask

    // Monitor: pops expected words and checks the status outputs each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr) begin
                wr_seen++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected actual=%08h required=no_write t=%0t", wr_data, $time);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (wr_data !== e) begin
                        bad++;
                        $display("FAIL wr_data actual=%08h required=%08h t=%0t", wr_data, e, $time);
                    end
                end
            end
            if (wr_load) load_seen++;
            check("status{busy,done,short,ovf,load,cnt}",
                  64'({busy, done, short_f, ovf, wr_load, pix_count}),
                  64'({m_armed | m_cap, m_done, m_short, m_ovf, m_load, CW'(m_cnt)}));
        end
    end

    // One frame: VS pulse, then nlines active lines of H pixels with blanking.
    task automatic frame(input int nlines, input int cap_line, input bit cap_vs,
                         input int full_lo, input int full_hi, input bit vs_last,
                         input int rst_px);
        bit vlow;
        vlow = 0;
        repeat (2) cyc(0, 1, 0, 1'($urandom_range(0, 1)), 0, 0, 0);
        cyc(cap_vs, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 0, 0);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < H; p++) begin
                int idx;
                bit c, f;
                logic [7:0] rr, gg, bb;
                idx = l * H + p;
                if (idx == rst_px) begin
                    rst_n = 1'b0;
                    #1;
                    check("reset_outputs_zero", pack_outputs(), 64'd0);
                    model_reset();
                    repeat (2) cyc(0, 1, 0, 0, 0, 0, 0);
                    rst_n = 1'b1;
                end
                c  = (cap_line >= 0) && (p == 0) && (l == cap_line || l == cap_line + 1);
                f  = (idx >= full_lo) && (idx <= full_hi);
                rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
                if (idx == 3) begin rr = 8'h12; gg = 8'h34; bb = 8'h56; end
                if (vs_last && l == nlines - 1 && p == H - 1) vlow = 1;
                cyc(c, !vlow, 1, f, rr, gg, bb);
            end
            repeat (3) cyc(0, !vlow, 0, 1'($urandom_range(0, 1)), 0, 0, 0);
        end
    endtask

    task automatic request();
        cyc(1, vs, 0, 0, 0, 0, 0);
    endtask

    task automatic end_checks(input string tn, input int wr_base, input int load_base,
                              input int exp_wr, input int exp_load, input bit e_done,
                              input bit e_short, input bit e_ovf, input int e_cnt);
        check({tn, "_wr_count"}, 64'(wr_seen - wr_base), 64'(exp_wr));
        check({tn, "_load_count"}, 64'(load_seen - load_base), 64'(exp_load));
        check({tn, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        check({tn, "_flags{done,short,ovf}"}, 64'({done, short_f, ovf}), 64'({e_done, e_short, e_ovf}));
        check({tn, "_pix_count"}, 64'(pix_count), 64'(e_cnt));
        check({tn, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int wb, lb, lo, hi;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pack_outputs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);

        // T1 + T2: full frame, second frame ignored; pixel 3 carries 12/34/56
        wb = wr_seen; lb = load_seen;
        request();
        check("t1_busy_armed", 64'(busy), 64'd1);
        frame(V, -1, 0, -1, -1, 0, -1);
        frame(V, -1, 0, -1, -1, 0, -1);
        end_checks("t1", wb, lb, TOTAL, 1, 1, 0, 0, TOTAL);

        // T3: FIFO full for pixels 2..5 of line 0
        wb = wr_seen; lb = load_seen;
        request();
        frame(V, -1, 0, 2, 5, 0, -1);
        end_checks("t3", wb, lb, TOTAL - 4, 1, 1, 0, 1, TOTAL);

        // T4: frame cut short by VS after 2 lines
        wb = wr_seen; lb = load_seen;
        request();
        frame(2, -1, 0, -1, -1, 0, -1);
        frame(V, -1, 0, -1, -1, 0, -1);
        end_checks("t4", wb, lb, 2 * H, 1, 1, 1, 0, 2 * H);

        // T5: request mid-frame at line 1, repeated at line 2 while armed
        wb = wr_seen; lb = load_seen;
        frame(V, 1, 0, -1, -1, 0, -1);
        check("t5_no_wr_before_vs", 64'(wr_seen - wb), 64'd0);
        frame(V, -1, 0, -1, -1, 0, -1);
        end_checks("t5", wb, lb, TOTAL, 1, 1, 0, 0, TOTAL);

        // Request coincident with VS fall arms only; then VS falls on the final pixel
        wb = wr_seen; lb = load_seen;
        frame(V, -1, 1, -1, -1, 0, -1);
        check("t7_armed_only_wr", 64'(wr_seen - wb), 64'd0);
        frame(V, -1, 0, -1, -1, 1, -1);
        frame(V, -1, 0, -1, -1, 0, -1);
        end_checks("t7", wb, lb, TOTAL, 1, 1, 0, 0, TOTAL);

        // Random FIFO-full window
        wb = wr_seen; lb = load_seen;
        lo = $urandom_range(0, TOTAL - 1);
        hi = lo + $urandom_range(0, 5);
        if (hi > TOTAL - 1) hi = TOTAL - 1;
        request();
        frame(V, -1, 0, lo, hi, 0, -1);
        end_checks("rand_full", wb, lb, TOTAL - (hi - lo + 1), 1, 1, 0, 1, TOTAL);

        // T6: reset at pixel 20; no further writes afterwards
        wb = wr_seen; lb = load_seen;
        request();
        frame(V, -1, 0, -1, -1, 0, 20);
        frame(V, -1, 0, -1, -1, 0, -1);
        end_checks("t6", wb, lb, 19, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
